// File: rtl/adain_pkg.sv
// Shared constants, handshake codes and FSM state type for the AdaIN feeder slice.
package adain_pkg;

  localparam int unsigned WIDTH_IN  = 48;
  localparam int unsigned WIDTH_OUT = 48;
  localparam int unsigned N_MAX     = 128;

  localparam logic [1:0] ADAIN_IDLE = 2'b00;
  localparam logic [1:0] ADAIN_SCAN = 2'b01;
  localparam logic [1:0] ADAIN_NORM = 2'b10;

  localparam logic [1:0] DONE_SCAN  = 2'b01;
  localparam logic [1:0] DONE_NORM  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRE1,
    ST_PASS1,
    ST_WAIT1,
    ST_PRE2,
    ST_PASS2,
    ST_WAIT2
  } feeder_state_t;

endpackage

// File: rtl/adain_fmap_ram.sv
// Simple dual-port feature-map buffer: one write port, one synchronous read port.
module adain_fmap_ram #(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/adain_feeder.sv
// Buffers one N x N feature map and replays it twice (scan, then normalize) into top_adain.
module adain_feeder #(
  parameter int unsigned WIDTH_IN = adain_pkg::WIDTH_IN,
  parameter int unsigned N_MAX    = adain_pkg::N_MAX
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(N_MAX+1)-1:0]   N,
  input  logic                         s_valid,
  input  logic [WIDTH_IN-1:0]          s_data,
  output logic                         s_ready,
  input  logic [WIDTH_IN-1:0]          ys_in,
  input  logic [WIDTH_IN-1:0]          yb_in,
  output logic [1:0]                   adain_start,
  output logic [WIDTH_IN-1:0]          adain_in,
  output logic [WIDTH_IN-1:0]          adain_ys,
  output logic [WIDTH_IN-1:0]          adain_yb,
  input  logic [1:0]                   adain_done,
  output logic                         busy,
  output logic                         frame_done
);

  import adain_pkg::*;

  localparam int unsigned DEPTH  = N_MAX * N_MAX;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned NW     = $clog2(N_MAX + 1);
  localparam int unsigned TW     = 2 * NW;

  feeder_state_t state, state_nx;

  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [TW-1:0]     n_sq;
  logic              n_ok;
  logic              accept;
  logic              last_wr;
  logic              last_rd;
  logic [1:0]        start_nx;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;

  assign n_ok    = (N != '0) && (32'(N) <= N_MAX);
  assign s_ready = ((state == ST_IDLE) && n_ok) || (state == ST_FILL);
  assign accept  = s_valid && s_ready;
  assign n_sq    = TW'(N) * TW'(N);
  assign last_wr = (wr_cnt == last_addr);
  assign last_rd = (rd_cnt == last_addr);

  assign ram_we    = accept;
  assign ram_waddr = (state == ST_IDLE) ? '0 : wr_cnt;

  // Reads run one address ahead of rd_cnt so that the registered RAM output
  // lines up with adain_start; no read is issued after the last word, so the
  // output register keeps presenting it through the WAIT states.
  always_comb begin
    state_nx  = state;
    ram_re    = 1'b0;
    ram_raddr = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = (N == NW'(1)) ? ST_PRE1 : ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept && last_wr) begin
          state_nx = ST_PRE1;
        end
      end
      ST_PRE1: begin
        ram_re   = 1'b1;
        state_nx = ST_PASS1;
      end
      ST_PASS1: begin
        if (last_rd) begin
          state_nx = ST_WAIT1;
        end else begin
          ram_re    = 1'b1;
          ram_raddr = rd_cnt + ADDR_W'(1);
        end
      end
      ST_WAIT1: begin
        if (adain_done == DONE_SCAN) begin
          state_nx = ST_PRE2;
        end
      end
      ST_PRE2: begin
        ram_re   = 1'b1;
        state_nx = ST_PASS2;
      end
      ST_PASS2: begin
        if (last_rd) begin
          state_nx = ST_WAIT2;
        end else begin
          ram_re    = 1'b1;
          ram_raddr = rd_cnt + ADDR_W'(1);
        end
      end
      ST_WAIT2: begin
        if (adain_done == DONE_NORM) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    start_nx = ADAIN_IDLE;
    if (state_nx == ST_PASS1) begin
      start_nx = ADAIN_SCAN;
    end else if (state_nx == ST_PASS2) begin
      start_nx = ADAIN_NORM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      last_addr   <= '0;
      adain_start <= ADAIN_IDLE;
      adain_ys    <= '0;
      adain_yb    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      adain_start <= start_nx;
      frame_done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            last_addr <= ADDR_W'(n_sq - TW'(1));
            adain_ys  <= ys_in;
            adain_yb  <= yb_in;
            busy      <= 1'b1;
            wr_cnt    <= ADDR_W'(1);
          end
        end
        ST_FILL: begin
          if (accept) begin
            wr_cnt <= wr_cnt + ADDR_W'(1);
          end
        end
        ST_PRE1, ST_PRE2: begin
          rd_cnt <= '0;
        end
        ST_PASS1, ST_PASS2: begin
          if (!last_rd) begin
            rd_cnt <= rd_cnt + ADDR_W'(1);
          end
        end
        ST_WAIT2: begin
          if (adain_done == DONE_NORM) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  adain_fmap_ram #(
    .WIDTH  (WIDTH_IN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (s_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (adain_in)
  );

endmodule
